morse_decoder_fifo: RTL and testbench

- Parametrised Morse symbol decoder; successor to the single-letter trie decoder.
- Accumulates dot/dash elements into a shift register and decodes the full international A–Z table (optionally 0–9) on commit.
- Commits on an explicit done pulse or an idle timeout; an empty commit emits a word space.
- Decoded ASCII characters are queued in an output FIFO with a valid/ready handshake toward the display/UART layer.
- Inputs are single-cycle pulses from the existing debouncer posedge outputs.

---
 rtl/morse_decoder_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_morse_decoder_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder_fifo.sv
// Morse symbol decoder with idle-timeout commit and an output character FIFO.
// Define MORSE_DIGITS_EN to decode the 5-element digit codes to "0".."9".
module morse_decoder_fifo #(
    parameter int          MAX_LEN        = 5,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 50000000,
    parameter logic [7:0]  ERR_CHAR       = 8'h3F
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               dot,
    input  logic                               dash,
    input  logic                               done,
    output logic [7:0]                         char_out,
    output logic                               char_valid,
    input  logic                               char_ready,
    output logic [$clog2(MAX_LEN+1)-1:0]       sym_len,
    output logic                               fifo_full,
    output logic                               fifo_ovf,
    output logic [7:0]                         err_count
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;

`ifdef MORSE_DIGITS_EN
    generate
        if (MAX_LEN < 5) begin : g_digit_len_check
            $error("MORSE_DIGITS_EN requires MAX_LEN >= 5");
        end
    endgenerate
`endif

    // Codes are right-aligned: the first element is the MSB of the len-bit field.
    function automatic logic [7:0] decode_sym(input logic [2:0] len, input logic [5:0] code);
        logic [7:0] ch;
        ch = ERR_CHAR;
        case ({len, code})
            {3'd1, 6'b000000}: ch = 8'h45; // E
            {3'd1, 6'b000001}: ch = 8'h54; // T
            {3'd2, 6'b000001}: ch = 8'h41; // A
            {3'd2, 6'b000000}: ch = 8'h49; // I
            {3'd2, 6'b000011}: ch = 8'h4D; // M
            {3'd2, 6'b000010}: ch = 8'h4E; // N
            {3'd3, 6'b000100}: ch = 8'h44; // D
            {3'd3, 6'b000110}: ch = 8'h47; // G
            {3'd3, 6'b000101}: ch = 8'h4B; // K
            {3'd3, 6'b000111}: ch = 8'h4F; // O
            {3'd3, 6'b000010}: ch = 8'h52; // R
            {3'd3, 6'b000000}: ch = 8'h53; // S
            {3'd3, 6'b000001}: ch = 8'h55; // U
            {3'd3, 6'b000011}: ch = 8'h57; // W
            {3'd4, 6'b001000}: ch = 8'h42; // B
            {3'd4, 6'b001010}: ch = 8'h43; // C
            {3'd4, 6'b000010}: ch = 8'h46; // F
            {3'd4, 6'b000000}: ch = 8'h48; // H
            {3'd4, 6'b000111}: ch = 8'h4A; // J
            {3'd4, 6'b000100}: ch = 8'h4C; // L
            {3'd4, 6'b000110}: ch = 8'h50; // P
            {3'd4, 6'b001101}: ch = 8'h51; // Q
            {3'd4, 6'b000001}: ch = 8'h56; // V
            {3'd4, 6'b001001}: ch = 8'h58; // X
            {3'd4, 6'b001011}: ch = 8'h59; // Y
            {3'd4, 6'b001100}: ch = 8'h5A; // Z
`ifdef MORSE_DIGITS_EN
            {3'd5, 6'b011111}: ch = 8'h30;
            {3'd5, 6'b001111}: ch = 8'h31;
            {3'd5, 6'b000111}: ch = 8'h32;
            {3'd5, 6'b000011}: ch = 8'h33;
            {3'd5, 6'b000001}: ch = 8'h34;
            {3'd5, 6'b000000}: ch = 8'h35;
            {3'd5, 6'b010000}: ch = 8'h36;
            {3'd5, 6'b011000}: ch = 8'h37;
            {3'd5, 6'b011100}: ch = 8'h38;
            {3'd5, 6'b011110}: ch = 8'h39;
`endif
            default:           ch = ERR_CHAR;
        endcase
        return ch;
    endfunction

    logic [MAX_LEN-1:0] code_r;
    logic [LEN_W-1:0]   sym_len_r;
    logic               overlong_r;
    logic [IDLE_W-1:0]  idle_r;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               valid_r, full_r, ovf_r;
    logic [7:0]         err_count_r;

    logic               commit_s, elem_s, pop_s, wr_en_s, ovf_set_s, is_err_s;
    logic [5:0]         code_ext_s;
    logic [7:0]         decoded_s, push_char_s;
    logic [CNT_W-1:0]   count_next_s;

    // Commit/element arbitration, symbol decode and FIFO handshake decisions.
    always_comb begin
        commit_s   = done | ((TIMEOUT_CYCLES != 0) && (sym_len_r != '0) && (idle_r == IDLE_LAST));
        elem_s     = !commit_s && (dot || dash);
        code_ext_s = 6'b000000;
        code_ext_s[MAX_LEN-1:0] = code_r;
        decoded_s  = decode_sym(3'(sym_len_r), code_ext_s);
        if (sym_len_r == '0) begin
            push_char_s = 8'h20;
            is_err_s    = 1'b0;
        end else if (overlong_r || (decoded_s == ERR_CHAR)) begin
            push_char_s = ERR_CHAR;
            is_err_s    = commit_s;
        end else begin
            push_char_s = decoded_s;
            is_err_s    = 1'b0;
        end
        pop_s     = valid_r && char_ready;
        wr_en_s   = commit_s && (!full_r || pop_s);
        ovf_set_s = commit_s && full_r && !pop_s;
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Symbol accumulator and idle timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_r     <= '0;
            sym_len_r  <= '0;
            overlong_r <= 1'b0;
            idle_r     <= '0;
        end else begin
            if (commit_s) begin
                code_r     <= '0;
                sym_len_r  <= '0;
                overlong_r <= 1'b0;
            end else if (elem_s) begin
                if (sym_len_r == LEN_W'(MAX_LEN)) begin
                    overlong_r <= 1'b1;
                end else begin
                    code_r    <= {code_r[MAX_LEN-2:0], dash};
                    sym_len_r <= sym_len_r + LEN_W'(1);
                end
            end else begin
                code_r <= code_r;
            end
            if (commit_s || dot || dash) begin
                idle_r <= '0;
            end else if ((sym_len_r != '0) && (TIMEOUT_CYCLES != 0)) begin
                idle_r <= idle_r + IDLE_W'(1);
            end else begin
                idle_r <= idle_r;
            end
        end
    end

    // Output character FIFO, overflow flag and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            valid_r     <= 1'b0;
            full_r      <= 1'b0;
            ovf_r       <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_char_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != '0);
            full_r  <= (count_next_s == CNT_W'(FIFO_DEPTH));
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
            if (is_err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign char_out   = mem_r[rd_ptr_r];
    assign char_valid = valid_r;
    assign sym_len    = sym_len_r;
    assign fifo_full  = full_r;
    assign fifo_ovf   = ovf_r;
    assign err_count  = err_count_r;
endmodule

// File: tb/tb_morse_decoder_fifo.sv
// Directed testbench for morse_decoder_fifo (MAX_LEN=5, FIFO_DEPTH=4, TIMEOUT_CYCLES=10).
module tb_morse_decoder_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dot = 1'b0, dash = 1'b0, done = 1'b0, char_ready = 1'b0;
    logic [7:0] char_out, err_count;
    logic       char_valid, fifo_full, fifo_ovf;
    logic [2:0] sym_len;
    int         vectors = 0;
    int         miscompares = 0;

    morse_decoder_fifo #(.MAX_LEN(5), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(10), .ERR_CHAR(8'h3F)) dut (
        .clk(clk), .reset(reset), .dot(dot), .dash(dash), .done(done),
        .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
        .sym_len(sym_len), .fifo_full(fifo_full), .fifo_ovf(fifo_ovf), .err_count(err_count)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic h, input logic c);
        dot = d; dash = h; done = c;
        tick();
        dot = 1'b0; dash = 1'b0; done = 1'b0;
    endtask

    task automatic pop_one();
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        vectors++; if (char_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", char_valid); miscompares++; end
        vectors++; if (char_out !== 8'h00) begin $display("FAIL reset_char: got %h want 00", char_out); miscompares++; end
        vectors++; if ({fifo_full, fifo_ovf} !== 2'b00) begin $display("FAIL reset_flags: got %b want 00", {fifo_full, fifo_ovf}); miscompares++; end
        vectors++; if ({sym_len, err_count} !== 11'd0) begin $display("FAIL reset_counts: got %h/%h want 0/0", sym_len, err_count); miscompares++; end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_letter_a();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        vectors++; if (sym_len !== 3'd2) begin $display("FAIL a_len: got %0d want 2", sym_len); miscompares++; end
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({char_valid, char_out} !== {1'b1, 8'h41}) begin $display("FAIL a_char: got %b/%h want 1/41", char_valid, char_out); miscompares++; end
        vectors++; if (sym_len !== 3'd0) begin $display("FAIL a_len_clear: got %0d want 0", sym_len); miscompares++; end
        pop_one();
        vectors++; if (char_valid !== 1'b0) begin $display("FAIL a_pop: got %b want 0", char_valid); miscompares++; end
    endtask

    task automatic test_sos();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({char_valid, fifo_full} !== 2'b10) begin $display("FAIL sos_fill: got %b want 10", {char_valid, fifo_full}); miscompares++; end
        vectors++; if (char_out !== 8'h53) begin $display("FAIL sos_head0: got %h want 53", char_out); miscompares++; end
        char_ready = 1'b1;
        tick();
        vectors++; if (char_out !== 8'h4F) begin $display("FAIL sos_head1: got %h want 4F", char_out); miscompares++; end
        tick();
        vectors++; if (char_out !== 8'h53) begin $display("FAIL sos_head2: got %h want 53", char_out); miscompares++; end
        tick();
        char_ready = 1'b0;
        vectors++; if (char_valid !== 1'b0) begin $display("FAIL sos_drained: got %b want 0", char_valid); miscompares++; end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({fifo_full, fifo_ovf, char_out} !== {2'b10, 8'h20}) begin $display("FAIL full_four: got %b%b/%h want 10/20", fifo_full, fifo_ovf, char_out); miscompares++; end
        char_ready = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        char_ready = 1'b0;
        vectors++; if ({fifo_full, fifo_ovf} !== 2'b10) begin $display("FAIL full_pushpop: got %b want 10", {fifo_full, fifo_ovf}); miscompares++; end
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({fifo_full, fifo_ovf} !== 2'b11) begin $display("FAIL full_ovf: got %b want 11", {fifo_full, fifo_ovf}); miscompares++; end
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({char_valid, char_out} !== {1'b1, 8'h20}) begin $display("FAIL full_drain%0d: got %b/%h want 1/20", i, char_valid, char_out); miscompares++; end
            tick();
        end
        char_ready = 1'b0;
        vectors++; if ({char_valid, fifo_full, fifo_ovf} !== 3'b001) begin $display("FAIL full_empty: got %b want 001", {char_valid, fifo_full, fifo_ovf}); miscompares++; end
    endtask

    task automatic test_overlong();
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
        vectors++; if (sym_len !== 3'd5) begin $display("FAIL ovl_len5: got %0d want 5", sym_len); miscompares++; end
        pulse(1'b1, 1'b0, 1'b0);
        vectors++; if (sym_len !== 3'd5) begin $display("FAIL ovl_len6: got %0d want 5", sym_len); miscompares++; end
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({char_out, err_count} !== {8'h3F, 8'd1}) begin $display("FAIL ovl_err: got %h/%0d want 3F/1", char_out, err_count); miscompares++; end
        pop_one();
        pulse(1'b1, 1'b0, 1'b0); pulse(1'b0, 1'b1, 1'b0); pulse(1'b1, 1'b0, 1'b0); pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({char_valid, char_out, err_count} !== {1'b1, 8'h3F, 8'd2}) begin $display("FAIL inv_err: got %b/%h/%0d want 1/3F/2", char_valid, char_out, err_count); miscompares++; end
        pop_one();
    endtask

    task automatic test_timeout();
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        vectors++; if ({char_valid, sym_len} !== {1'b0, 3'd1}) begin $display("FAIL to_early: got %b/%0d want 0/1", char_valid, sym_len); miscompares++; end
        tick();
        vectors++; if ({char_valid, char_out, sym_len} !== {1'b1, 8'h54, 3'd0}) begin $display("FAIL to_commit: got %b/%h/%0d want 1/54/0", char_valid, char_out, sym_len); miscompares++; end
        pop_one();
        for (int i = 0; i < 20; i++) tick();
        vectors++; if (char_valid !== 1'b0) begin $display("FAIL to_idle_empty: got %b want 0", char_valid); miscompares++; end
        pulse(1'b1, 1'b0, 1'b1);
        vectors++; if ({char_valid, char_out, sym_len} !== {1'b1, 8'h20, 3'd0}) begin $display("FAIL to_dot_done: got %b/%h/%0d want 1/20/0", char_valid, char_out, sym_len); miscompares++; end
        pop_one();
        vectors++; if (char_valid !== 1'b0) begin $display("FAIL to_single: got %b want 0", char_valid); miscompares++; end
        pulse(1'b1, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if ({char_valid, char_out} !== {1'b1, 8'h54}) begin $display("FAIL dash_prio: got %b/%h want 1/54", char_valid, char_out); miscompares++; end
        pop_one();
    endtask

    task automatic test_digits();
        logic [7:0] exp5, exp0, exp_err;
`ifdef MORSE_DIGITS_EN
        exp5 = 8'h35; exp0 = 8'h30; exp_err = 8'd0;
`else
        exp5 = 8'h3F; exp0 = 8'h3F; exp_err = 8'd2;
`endif
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if (char_out !== exp5) begin $display("FAIL digit5: got %h want %h", char_out, exp5); miscompares++; end
        pop_one();
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        vectors++; if (char_out !== exp0) begin $display("FAIL digit0: got %h want %h", char_out, exp0); miscompares++; end
        pop_one();
        vectors++; if (err_count !== exp_err) begin $display("FAIL digit_err: got %0d want %0d", err_count, exp_err); miscompares++; end
    endtask

    task automatic test_reset_mid_symbol();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        vectors++; if (sym_len !== 3'd2) begin $display("FAIL mid_len: got %0d want 2", sym_len); miscompares++; end
        #2 reset = 1'b1;
        #1;
        vectors++; if (sym_len !== 3'd0) begin $display("FAIL mid_async: got %0d want 0", sym_len); miscompares++; end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        vectors++; if ({char_valid, sym_len} !== {1'b0, 3'd0}) begin $display("FAIL mid_noqueue: got %b/%0d want 0/0", char_valid, sym_len); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_sos();
        apply_reset();
        test_fifo_full();
        apply_reset();
        test_overlong();
        apply_reset();
        test_timeout();
        apply_reset();
        test_digits();
        test_reset_mid_symbol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
